// File: rtl/vx_fpu_req_tracker_pkg.sv
// Shared types for the FPU request tracker: thread/opcode widths, fflags and per-tag metadata.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package vx_fpu_req_tracker_pkg;

  localparam int NUM_THREADS   = 4;
  localparam int INST_FPU_BITS = 4;
  localparam int INST_MOD_BITS = 3;
  localparam int META_W        = 64;
  localparam int NW            = 4;
  localparam int NW_BITS       = (NW > 1) ? $clog2(NW) : 1;

  // IEEE exception flags, NV in the MSB.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Everything the requester must remember about an in-flight tag.
  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [META_W-1:0]      meta;
  } fpu_trk_meta_t;

  // OR of the flags raised by the active threads only.
  function automatic fflags_t fflags_reduce(input fflags_t [NUM_THREADS-1:0] flags,
                                            input logic [NUM_THREADS-1:0]    tmask);
    fflags_t acc;
    acc = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (tmask[t]) acc = fflags_t'(acc | flags[t]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vx_fpu_req_tracker_tag_alloc.sv
// Tag allocator: free mask, lowest-free-tag priority encoder, pending count and full flag.
// Latency: alloc_tag is combinational from the registered mask; alloc/free take effect next cycle.
// Backpressure: none internally; the caller must not alloc while full nor free a tag that is not busy.
//
// Ports: clk, reset (sync, active-high); alloc_en/alloc_tag; free_en/free_tag;
//        full, pending (TAGW+1 bits), busy_mask (one bit per tag).
module vx_fpu_req_tracker_tag_alloc
  import vx_fpu_req_tracker_pkg::*;
#(
  parameter int TAGW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_en,
  output logic [TAGW-1:0]      alloc_tag,
  input  logic                 free_en,
  input  logic [TAGW-1:0]      free_tag,
  output logic                 full,
  output logic [TAGW:0]        pending,
  output logic [2**TAGW-1:0]   busy_mask
);

  localparam int NTAGS = 2**TAGW;

  logic [NTAGS-1:0] busy_n;
  logic [TAGW:0]    pending_n;

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    alloc_tag = '0;
    for (int i = NTAGS-1; i >= 0; i--) begin
      if (!busy_mask[i]) alloc_tag = TAGW'(i);
    end
  end

  assign full = (pending == (TAGW+1)'(NTAGS));

  // The allocated tag comes from the pre-cycle mask, so it can never be the tag
  // being freed this cycle; a freed tag only becomes allocatable next cycle.
  always_comb begin
    busy_n    = busy_mask;
    pending_n = pending;
    if (free_en)  busy_n[free_tag]  = 1'b0;
    if (alloc_en) busy_n[alloc_tag] = 1'b1;
    case ({alloc_en, free_en})
      2'b10:   pending_n = pending + 1'b1;
      2'b01:   pending_n = pending - 1'b1;
      default: pending_n = pending;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask <= '0;
      pending   <= '0;
    end else begin
      busy_mask <= busy_n;
      pending   <= pending_n;
    end
  end

endmodule

// File: rtl/vx_fpu_req_tracker.sv
// FPU requester front end: tags issues, forwards them to the FPU, commits responses in any order.
// Latency: issue is a zero-cycle pass-through; response to commit_valid is 1 cycle.
// Backpressure: req_ready follows fpu_ready_in and tag availability; fpu_ready_out drops while a commit is stalled.
//
// Ports: clk, reset (sync, active-high)
//        req_*        dispatch issue (valid/ready, wid, tmask, meta, op_type, frm, dataa/b/c)
//        fpu_*_in     request to FPU (valid/ready, tag, op/frm/data pass-through)
//        fpu_*_out    FPU response (valid/ready, tag, result, has_fflags, fflags)
//        commit_*     registered commit (valid/ready, wid, tmask, meta, result, tag)
//        fflags_clr_* per-warp flag clear; fflags_acc accumulated flags; pending outstanding count
// Optional: FPU_TRACKER_PERF_EN adds perf_stall_cycles and perf_occupancy (44-bit, wrapping).
module vx_fpu_req_tracker
  import vx_fpu_req_tracker_pkg::*;
#(
  parameter int TAGW = 4
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NW_BITS-1:0]            req_wid,
  input  logic [NUM_THREADS-1:0]        req_tmask,
  input  logic [META_W-1:0]             req_meta,
  input  logic [INST_FPU_BITS-1:0]      req_op_type,
  input  logic [INST_MOD_BITS-1:0]      req_frm,
  input  logic [NUM_THREADS*32-1:0]     req_dataa,
  input  logic [NUM_THREADS*32-1:0]     req_datab,
  input  logic [NUM_THREADS*32-1:0]     req_datac,

  output logic                          fpu_valid_in,
  input  logic                          fpu_ready_in,
  output logic [TAGW-1:0]               fpu_tag_in,
  output logic [INST_FPU_BITS-1:0]      fpu_op_type,
  output logic [INST_MOD_BITS-1:0]      fpu_frm,
  output logic [NUM_THREADS*32-1:0]     fpu_dataa,
  output logic [NUM_THREADS*32-1:0]     fpu_datab,
  output logic [NUM_THREADS*32-1:0]     fpu_datac,

  input  logic                          fpu_valid_out,
  output logic                          fpu_ready_out,
  input  logic [TAGW-1:0]               fpu_tag_out,
  input  logic [NUM_THREADS*32-1:0]     fpu_result,
  input  logic                          fpu_has_fflags,
  input  fflags_t [NUM_THREADS-1:0]     fpu_fflags,

  output logic                          commit_valid,
  input  logic                          commit_ready,
  output logic [NW_BITS-1:0]            commit_wid,
  output logic [NUM_THREADS-1:0]        commit_tmask,
  output logic [META_W-1:0]             commit_meta,
  output logic [NUM_THREADS*32-1:0]     commit_result,
  output logic [TAGW-1:0]               commit_tag,

  input  logic                          fflags_clr_valid,
  input  logic [NW_BITS-1:0]            fflags_clr_wid,
  output fflags_t [NW-1:0]              fflags_acc,
  output logic [TAGW:0]                 pending
`ifdef FPU_TRACKER_PERF_EN
  ,
  output logic [43:0]                   perf_stall_cycles,
  output logic [43:0]                   perf_occupancy
`endif
);

  localparam int NTAGS = 2**TAGW;

  logic             full;
  logic             issue_fire;
  logic             rsp_fire;
  logic [NTAGS-1:0] busy_mask;
  fpu_trk_meta_t    meta_tbl [NTAGS];
  fpu_trk_meta_t    rsp_meta;
  fflags_t          rsp_flags;
  fflags_t [NW-1:0] fflags_acc_n;

  // Issue path: pure pass-through, gated only by tag availability.
  assign fpu_valid_in = req_valid && !full;
  assign req_ready    = fpu_ready_in && !full;
  assign issue_fire   = req_valid && req_ready;
  assign fpu_op_type  = req_op_type;
  assign fpu_frm      = req_frm;
  assign fpu_dataa    = req_dataa;
  assign fpu_datab    = req_datab;
  assign fpu_datac    = req_datac;

  // Single commit register behaves as a pipe stage: it can reload in the cycle it drains.
  assign fpu_ready_out = !commit_valid || commit_ready;
  assign rsp_fire      = fpu_valid_out && fpu_ready_out;

  vx_fpu_req_tracker_tag_alloc #(.TAGW(TAGW)) u_tag_alloc (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (issue_fire),
    .alloc_tag (fpu_tag_in),
    .free_en   (rsp_fire),
    .free_tag  (fpu_tag_out),
    .full      (full),
    .pending   (pending),
    .busy_mask (busy_mask)
  );

  // Metadata table needs no reset: an entry is only read after its tag was written.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      meta_tbl[fpu_tag_in] <= '{wid: req_wid, tmask: req_tmask, meta: req_meta};
    end
  end

  assign rsp_meta = meta_tbl[fpu_tag_out];

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_valid <= 1'b0;
    end else if (rsp_fire) begin
      commit_valid <= 1'b1;
    end else if (commit_ready) begin
      commit_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_fire) begin
      commit_wid    <= rsp_meta.wid;
      commit_tmask  <= rsp_meta.tmask;
      commit_meta   <= rsp_meta.meta;
      commit_result <= fpu_result;
      commit_tag    <= fpu_tag_out;
    end
  end

  // Clear is applied before accumulate, so a same-warp collision keeps only the new flags.
  assign rsp_flags = fflags_reduce(fpu_fflags, rsp_meta.tmask);

  always_comb begin
    fflags_acc_n = fflags_acc;
    for (int w = 0; w < NW; w++) begin
      if (fflags_clr_valid && (fflags_clr_wid == NW_BITS'(w))) begin
        fflags_acc_n[w] = '0;
      end
      if (rsp_fire && fpu_has_fflags && (rsp_meta.wid == NW_BITS'(w))) begin
        fflags_acc_n[w] = fflags_t'(fflags_acc_n[w] | rsp_flags);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fflags_acc <= '0;
    else       fflags_acc <= fflags_acc_n;
  end

`ifdef FPU_TRACKER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_occupancy    <= '0;
    end else begin
      if (req_valid && !req_ready) perf_stall_cycles <= perf_stall_cycles + 44'd1;
      perf_occupancy <= perf_occupancy + 44'(pending);
    end
  end
`endif

  // A response must name a tag that is currently outstanding.
  rsp_tag_busy: assert property (@(posedge clk) disable iff (reset) rsp_fire |-> busy_mask[fpu_tag_out]);

endmodule

// File: tb/tb_vx_fpu_req_tracker.sv
// Bench for vx_fpu_req_tracker: directed issue/response sequences, commits checked by a scoreboard.
// Latency: n/a.
// Backpressure: commit_ready is toggled by the stimulus to exercise stalls.
module tb_vx_fpu_req_tracker;
  import vx_fpu_req_tracker_pkg::*;

  localparam int TAGW = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      req_valid;
  logic                      req_ready;
  logic [NW_BITS-1:0]        req_wid;
  logic [NUM_THREADS-1:0]    req_tmask;
  logic [META_W-1:0]         req_meta;
  logic [INST_FPU_BITS-1:0]  req_op_type;
  logic [INST_MOD_BITS-1:0]  req_frm;
  logic [NUM_THREADS*32-1:0] req_dataa, req_datab, req_datac;
  logic                      fpu_valid_in;
  logic                      fpu_ready_in;
  logic [TAGW-1:0]           fpu_tag_in;
  logic [INST_FPU_BITS-1:0]  fpu_op_type;
  logic [INST_MOD_BITS-1:0]  fpu_frm;
  logic [NUM_THREADS*32-1:0] fpu_dataa, fpu_datab, fpu_datac;
  logic                      fpu_valid_out;
  logic                      fpu_ready_out;
  logic [TAGW-1:0]           fpu_tag_out;
  logic [NUM_THREADS*32-1:0] fpu_result;
  logic                      fpu_has_fflags;
  fflags_t [NUM_THREADS-1:0] fpu_fflags;
  logic                      commit_valid;
  logic                      commit_ready;
  logic [NW_BITS-1:0]        commit_wid;
  logic [NUM_THREADS-1:0]    commit_tmask;
  logic [META_W-1:0]         commit_meta;
  logic [NUM_THREADS*32-1:0] commit_result;
  logic [TAGW-1:0]           commit_tag;
  logic                      fflags_clr_valid;
  logic [NW_BITS-1:0]        fflags_clr_wid;
  fflags_t [NW-1:0]          fflags_acc;
  logic [TAGW:0]             pending;
`ifdef FPU_TRACKER_PERF_EN
  logic [43:0]               perf_stall_cycles;
  logic [43:0]               perf_occupancy;
`endif

  vx_fpu_req_tracker #(.TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_tmask(req_tmask),
    .req_meta(req_meta), .req_op_type(req_op_type), .req_frm(req_frm),
    .req_dataa(req_dataa), .req_datab(req_datab), .req_datac(req_datac),
    .fpu_valid_in(fpu_valid_in), .fpu_ready_in(fpu_ready_in), .fpu_tag_in(fpu_tag_in),
    .fpu_op_type(fpu_op_type), .fpu_frm(fpu_frm),
    .fpu_dataa(fpu_dataa), .fpu_datab(fpu_datab), .fpu_datac(fpu_datac),
    .fpu_valid_out(fpu_valid_out), .fpu_ready_out(fpu_ready_out), .fpu_tag_out(fpu_tag_out),
    .fpu_result(fpu_result), .fpu_has_fflags(fpu_has_fflags), .fpu_fflags(fpu_fflags),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_wid(commit_wid),
    .commit_tmask(commit_tmask), .commit_meta(commit_meta), .commit_result(commit_result),
    .commit_tag(commit_tag),
    .fflags_clr_valid(fflags_clr_valid), .fflags_clr_wid(fflags_clr_wid),
    .fflags_acc(fflags_acc), .pending(pending)
`ifdef FPU_TRACKER_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_occupancy(perf_occupancy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW_BITS-1:0]        wid;
    logic [NUM_THREADS-1:0]    tmask;
    logic [META_W-1:0]         meta;
    logic [NUM_THREADS*32-1:0] result;
    logic [TAGW-1:0]           tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [4:0] NV = 5'b10000;
  localparam logic [4:0] NX = 5'b00001;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Scoreboard monitor: every commit handshake pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && commit_valid && commit_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit_tag", commit_tag, '1);
        end else begin
          e = exp_q.pop_front();
          chk("commit_wid",    commit_wid,    e.wid);
          chk("commit_tmask",  commit_tmask,  e.tmask);
          chk("commit_meta",   commit_meta,   e.meta);
          chk("commit_result", commit_result, e.result);
          chk("commit_tag",    commit_tag,    e.tag);
        end
      end
    end
  end

  task automatic issue(input logic [NW_BITS-1:0] wid, input logic [3:0] tmask,
                       input logic [63:0] meta, input int exp_tag);
    @(negedge clk);
    req_valid   = 1'b1;
    req_wid     = wid;
    req_tmask   = tmask;
    req_meta    = meta;
    req_op_type = 4'h0;  // FPU_ADD
    req_dataa   = {4{32'h3f800000}};
    req_datab   = {4{32'h40000000}};
    #1;
    chk("issue_ready", req_ready, 1'b1);
    chk("issue_tag",   fpu_tag_in, exp_tag[TAGW-1:0]);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Drives one response; if push is set, the hand-computed commit is queued.
  task automatic respond(input logic [TAGW-1:0] tag, input logic [31:0] res,
                         input logic has_ff, input logic [19:0] ff,
                         input logic [NW_BITS-1:0] e_wid, input logic [3:0] e_tmask,
                         input logic [63:0] e_meta, input logic push);
    int budget;
    @(negedge clk);
    fpu_valid_out  = 1'b1;
    fpu_tag_out    = tag;
    fpu_result     = {4{res}};
    fpu_has_fflags = has_ff;
    fpu_fflags     = ff;
    budget = 0;
    #1;
    while (!fpu_ready_out && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("rsp_accept", fpu_ready_out, 1'b1);
    if (push) exp_q.push_back('{wid: e_wid, tmask: e_tmask, meta: e_meta, result: {4{res}}, tag: tag});
    @(posedge clk);
    #1;
    fpu_valid_out  = 1'b0;
    fpu_has_fflags = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_wid = 0; req_tmask = 0; req_meta = 0; req_op_type = 0; req_frm = 0;
    req_dataa = 0; req_datab = 0; req_datac = 0;
    fpu_ready_in = 1'b1;
    fpu_valid_out = 0; fpu_tag_out = 0; fpu_result = 0; fpu_has_fflags = 0; fpu_fflags = '0;
    commit_ready = 1'b1;
    fflags_clr_valid = 0; fflags_clr_wid = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pending",      pending,      0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_fflags",       fflags_acc,   0);
    chk("rst_req_ready",    req_ready,    1);

    // 1: single round trip
    issue(1, 4'hF, 64'hA5, 0);
    chk("t1_pending_1", pending, 1);
    respond(0, 32'h40400000, 0, '0, 1, 4'hF, 64'hA5, 1);
    chk("t1_pending_0", pending, 0);
    chk("t1_commit_valid", commit_valid, 1);

    // 2: fill all 16 tags, then free tag 5 and reallocate it
    for (int i = 0; i < 16; i++) issue(0, 4'h1, 64'h100 + i, i);
    chk("t2_pending_full", pending, 16);
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("t2_full_req_ready", req_ready, 0);
    chk("t2_full_valid_in",  fpu_valid_in, 0);
    req_valid = 1'b0;
    respond(5, 32'h5, 0, '0, 0, 4'h1, 64'h105, 1);
    issue(0, 4'h1, 64'h200, 5);
    chk("t2_pending_refill", pending, 16);
    for (int i = 0; i < 16; i++)
      respond(i[TAGW-1:0], 32'h1000 + i, 0, '0, 0, 4'h1, (i == 5) ? 64'h200 : 64'h100 + i, 1);
    chk("t2_pending_drained", pending, 0);

    // 3: out-of-order responses
    for (int i = 0; i < 4; i++) issue(3, 4'h7, 64'h30 + i, i);
    respond(3, 32'h33, 0, '0, 3, 4'h7, 64'h33, 1);
    respond(1, 32'h31, 0, '0, 3, 4'h7, 64'h31, 1);
    respond(2, 32'h32, 0, '0, 3, 4'h7, 64'h32, 1);
    respond(0, 32'h30, 0, '0, 3, 4'h7, 64'h30, 1);

    // 4: commit stall with a second response waiting
    issue(2, 4'hF, 64'h41, 0);
    issue(2, 4'hF, 64'h42, 1);
    commit_ready = 1'b0;
    respond(0, 32'h41000000, 0, '0, 2, 4'hF, 64'h41, 1);
    @(negedge clk);
    fpu_valid_out = 1'b1;
    fpu_tag_out   = 1;
    fpu_result    = {4{32'h42000000}};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_ready_out_low", fpu_ready_out, 0);
      chk("t4_commit_valid",  commit_valid,  1);
      chk("t4_commit_meta",   commit_meta,   64'h41);
      @(negedge clk);
    end
    commit_ready = 1'b1;
    exp_q.push_back('{wid: 2, tmask: 4'hF, meta: 64'h42, result: {4{32'h42000000}}, tag: 1});
    #1;
    chk("t4_ready_out_high", fpu_ready_out, 1);
    @(posedge clk);
    #1;
    fpu_valid_out = 1'b0;

    // 5: fflags masking, same-warp clear+accumulate, other-warp clear
    issue(2, 4'b0011, 64'h50, 0);
    respond(0, 32'h50, 1, {5'b0, NX, 5'b0, NV}, 2, 4'b0011, 64'h50, 1);
    chk("t5_acc2_nv", fflags_acc[2], NV);
    issue(2, 4'hF, 64'h51, 0);
    fflags_clr_valid = 1'b1;
    fflags_clr_wid   = 2;
    respond(0, 32'h51, 1, {4{NX}}, 2, 4'hF, 64'h51, 1);
    fflags_clr_valid = 1'b0;
    chk("t5_acc2_nx", fflags_acc[2], NX);
    issue(1, 4'hF, 64'h52, 0);
    fflags_clr_valid = 1'b1;
    fflags_clr_wid   = 2;
    respond(0, 32'h52, 1, {4{NV}}, 1, 4'hF, 64'h52, 1);
    fflags_clr_valid = 1'b0;
    chk("t5_acc1_nv",  fflags_acc[1], NV);
    chk("t5_acc2_clr", fflags_acc[2], 0);

    // 6: reset with 5 pending and a held commit
    for (int i = 0; i < 6; i++) issue(0, 4'h3, 64'h60 + i, i);
    commit_ready = 1'b0;
    respond(0, 32'h60, 0, '0, 0, 4'h3, 64'h60, 0);
    chk("t6_pending_5",  pending, 5);
    chk("t6_commit_held", commit_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    commit_ready = 1'b1;
    #1;
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_commit",  commit_valid, 0);
    issue(3, 4'hF, 64'h70, 0);
    respond(0, 32'h70, 0, '0, 3, 4'hF, 64'h70, 1);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
